// File: rtl/ahb_lite_arbiter2_if.sv
// One AHB-Lite link (address/data phase signals plus ready/read data).
// The arbiter takes one link per master (slave modport) and drives
// one link toward the shared slave (master modport).
interface ahb_lite_arbiter2_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]    HTRANS;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [DW-1:0] HWDATA;
    logic [DW-1:0] HRDATA;
    logic          HREADY;

    // Bus master side: issues transfers, sees ready and read data
    modport master (
        output HTRANS, HADDR, HWRITE, HWDATA,
        input  HRDATA, HREADY
    );

    // Bus slave side: accepts transfers, returns ready and read data
    modport slave (
        input  HTRANS, HADDR, HWRITE, HWDATA,
        output HRDATA, HREADY
    );
endinterface

// File: rtl/ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter in front of a single slave bus.
// A losing live request is parked in a one-entry pending slot per master;
// that master is held off on its own HREADY until the parked address has
// been issued. Word transfers only; SEQ is handled as NONSEQ.
module ahb_lite_arbiter2 #(
    parameter bit PRIORITY_MODE = 1'b0,  // 0: round-robin, 1: M0 always wins ties
    parameter int AW            = 32,
    parameter int DW            = 32
) (
    input  logic                SI_ClkIn,
    input  logic                SI_Reset,
    ahb_lite_arbiter2_if.slave  m0,
    ahb_lite_arbiter2_if.slave  m1,
    ahb_lite_arbiter2_if.master s
);
    typedef struct packed {
        logic [AW-1:0] addr;
        logic          write;
    } req_t;

    // Per-master views of the incoming links
    req_t [1:0]          live_req;
    logic [1:0]          req_on;
    logic [1:0][DW-1:0]  mst_wdata;

    assign live_req[0]  = {m0.HADDR, m0.HWRITE};
    assign live_req[1]  = {m1.HADDR, m1.HWRITE};
    assign req_on       = {m1.HTRANS[1], m0.HTRANS[1]};
    assign mst_wdata[0] = m0.HWDATA;
    assign mst_wdata[1] = m1.HWDATA;

    // Registered state
    logic [1:0] pend_v_q, pend_v_d;
    req_t [1:0] pend_q,   pend_d;
    logic       dp_v_q,   dp_v_d;
    logic       dp_own_q, dp_own_d;
    logic       last_q,   last_d;

    // Arbitration results
    logic [1:0] live;
    logic [1:0] cand;
    logic       win_v;
    logic       win;
    req_t       win_req;

    // Pick a winner from pending slots and live requests. Depends only on
    // registered state and held master inputs, so during a slave wait state
    // the same address stays on the bus.
    always_comb begin
        live  = req_on & ~pend_v_q;
        cand  = pend_v_q | live;
        win_v = |cand;
        win   = 1'b0;
        if (cand == 2'b11) begin
            win = PRIORITY_MODE ? 1'b0 : ~last_q;
        end else begin
            win = cand[1];
        end
        win_req = pend_v_q[win] ? pend_q[win] : live_req[win];
    end

    // Slave address/data phase outputs, forced idle while in reset
    always_comb begin
        s.HTRANS = 2'b00;
        s.HADDR  = '0;
        s.HWRITE = 1'b0;
        s.HWDATA = '0;
        if (!SI_Reset) begin
            if (win_v) begin
                s.HTRANS = 2'b10;
                s.HADDR  = win_req.addr;
                s.HWRITE = win_req.write;
            end
            if (dp_v_q) begin
                s.HWDATA = mst_wdata[dp_own_q];
            end
        end
    end

    // A master with a parked address is stalled until it has been issued;
    // its later data phase then completes on the slave HREADY.
    assign m0.HREADY = SI_Reset | (s.HREADY & ~pend_v_q[0]);
    assign m1.HREADY = SI_Reset | (s.HREADY & ~pend_v_q[1]);
    assign m0.HRDATA = s.HRDATA;
    assign m1.HRDATA = s.HRDATA;

    // Next-state: advance only when the slave is ready, otherwise hold
    always_comb begin
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        dp_v_d   = dp_v_q;
        dp_own_d = dp_own_q;
        last_d   = last_q;
        if (s.HREADY) begin
            dp_v_d   = win_v;
            dp_own_d = win;
            if (win_v) begin
                last_d = win;
            end
            for (int x = 0; x < 2; x++) begin
                if (win_v && (win == 1'(x))) begin
                    pend_v_d[x] = 1'b0;
                end else if (live[x]) begin
                    // Lost this round: park the address, master is stalled
                    pend_v_d[x] = 1'b1;
                    pend_d[x]   = live_req[x];
                end
            end
        end
    end

    // State register with synchronous reset; reset drops anything parked
    // or in flight, and last=1 lets M0 win the first tie.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            pend_v_q <= '0;
            pend_q   <= '0;
            dp_v_q   <= 1'b0;
            dp_own_q <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            dp_v_q   <= dp_v_d;
            dp_own_q <= dp_own_d;
            last_q   <= last_d;
        end
    end
endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// Bench for ahb_lite_arbiter2: a round-robin and a fixed-priority instance,
// behavioural AHB masters fed from transfer queues, a slave model with
// injectable wait states, and a per-instance scoreboard monitor.
module tb_ahb_lite_arbiter2;
    typedef struct packed {
        logic        mst;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or expected read data
    } xfer_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    errors = 0;
    int    checks = 0;
    xfer_t mq[4][$];      // master stimulus: index = dut*2 + master
    xfer_t exp_q[2][$];   // expected slave-side transfer order per dut
    int    stall[2] = '{0, 0};

    always #5 clk = ~clk;

    ahb_lite_arbiter2_if #(.AW(32), .DW(32)) mif[4] ();
    ahb_lite_arbiter2_if #(.AW(32), .DW(32)) sif[2] ();

    ahb_lite_arbiter2 #(.PRIORITY_MODE(1'b0), .AW(32), .DW(32)) u_rr (
        .SI_ClkIn(clk), .SI_Reset(rst), .m0(mif[0]), .m1(mif[1]), .s(sif[0]));
    ahb_lite_arbiter2 #(.PRIORITY_MODE(1'b1), .AW(32), .DW(32)) u_fp (
        .SI_ClkIn(clk), .SI_Reset(rst), .m0(mif[2]), .m1(mif[3]), .s(sif[1]));

    function automatic xfer_t mk(logic m, logic w, logic [31:0] a, logic [31:0] d);
        xfer_t t;
        t.mst = m; t.wr = w; t.addr = a; t.data = d;
        return t;
    endfunction

    function automatic logic [31:0] rdval(logic [31:0] a);
        return (a == 32'hBFC00000) ? 32'hDEADBEEF : ~a;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural masters: hold address/data while own HREADY is low
    for (genvar g = 0; g < 4; g++) begin : g_mst
        xfer_t ap, dp;
        logic  ap_v = 1'b0, dp_v = 1'b0, rdy_s, rst_s;
        initial begin
            mif[g].HTRANS = 2'b00; mif[g].HADDR = '0; mif[g].HWRITE = 1'b0; mif[g].HWDATA = '0;
            forever begin
                @(negedge clk);
                rdy_s = mif[g].HREADY;
                rst_s = rst;
                @(posedge clk);
                #1;
                if (rst_s) begin
                    ap_v = 1'b0; dp_v = 1'b0;
                end else if (rdy_s) begin
                    dp = ap; dp_v = ap_v; ap_v = 1'b0;
                    if (mq[g].size() > 0) begin ap = mq[g].pop_front(); ap_v = 1'b1; end
                end
                mif[g].HTRANS = ap_v ? 2'b10 : 2'b00;
                mif[g].HADDR  = ap_v ? ap.addr : 32'h0;
                mif[g].HWRITE = ap_v & ap.wr;
                mif[g].HWDATA = (dp_v && dp.wr) ? dp.data : 32'h0;
            end
        end
    end

    // Slave models and scoreboard monitors, one per dut
    for (genvar d = 0; d < 2; d++) begin : g_slv
        logic        acc, aw, r;
        logic [31:0] aa;
        xfer_t       cur;
        logic        cur_v = 1'b0;
        initial begin
            sif[d].HREADY = 1'b1; sif[d].HRDATA = '0;
            forever begin
                @(negedge clk);
                acc = sif[d].HTRANS[1] & sif[d].HREADY;
                aw  = sif[d].HWRITE;
                aa  = sif[d].HADDR;
                r   = sif[d].HREADY;
                @(posedge clk);
                #1;
                if (r) sif[d].HRDATA = (acc && !aw) ? rdval(aa) : 32'h0;
                sif[d].HREADY = (stall[d] > 0) ? 1'b0 : 1'b1;
                if (stall[d] > 0) stall[d]--;
            end
        end
        initial begin
            forever begin
                @(negedge clk);
                if (rst) begin
                    cur_v = 1'b0;
                end else if (sif[d].HREADY) begin
                    if (cur_v) begin
                        if (cur.wr) chk($sformatf("hwdata[dut%0d]", d), sif[d].HWDATA, cur.data);
                        else chk($sformatf("hrdata[dut%0d]", d),
                                 cur.mst ? mif[2*d+1].HRDATA : mif[2*d].HRDATA, cur.data);
                        chk($sformatf("owner_hready[dut%0d]", d),
                            {31'b0, cur.mst ? mif[2*d+1].HREADY : mif[2*d].HREADY}, 32'd1);
                        cur_v = 1'b0;
                    end
                    if (sif[d].HTRANS[1]) begin
                        if (exp_q[d].size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_addr[dut%0d]: got %h expected none", d, sif[d].HADDR);
                        end else begin
                            cur = exp_q[d].pop_front();
                            chk($sformatf("haddr[dut%0d]", d), sif[d].HADDR, cur.addr);
                            chk($sformatf("hwrite[dut%0d]", d), {31'b0, sif[d].HWRITE}, {31'b0, cur.wr});
                            cur_v = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic reset_all();
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_htrans", {30'b0, sif[0].HTRANS}, 32'd0);
        chk("rst_haddr", sif[0].HADDR, 32'd0);
        chk("rst_hwrite", {31'b0, sif[0].HWRITE}, 32'd0);
        chk("rst_hwdata", sif[0].HWDATA, 32'd0);
        chk("rst_m0_hready", {31'b0, mif[0].HREADY}, 32'd1);
        chk("rst_m1_hready", {31'b0, mif[1].HREADY}, 32'd1);
        @(posedge clk); #2 rst = 1'b0;
    endtask

    initial begin
        xfer_t t;
        // 1: lone M0 write, combinational pass-through
        reset_all();
        @(negedge clk);
        t = mk(1'b0, 1'b1, 32'h1F800000, 32'h12345678);
        mq[0].push_back(t); exp_q[0].push_back(t);
        @(negedge clk);
        chk("t1_haddr", sif[0].HADDR, 32'h1F800000);
        chk("t1_htrans", {30'b0, sif[0].HTRANS}, 32'd2);
        chk("t1_hwrite", {31'b0, sif[0].HWRITE}, 32'd1);
        chk("t1_m0_hready_a", {31'b0, mif[0].HREADY}, 32'd1);
        @(negedge clk);
        chk("t1_hwdata", sif[0].HWDATA, 32'h12345678);
        chk("t1_m0_hready_d", {31'b0, mif[0].HREADY}, 32'd1);

        // 2: simultaneous writes, M0 first after reset, M1 parked one slot
        reset_all();
        @(negedge clk);
        t = mk(1'b0, 1'b1, 32'h100, 32'hA0A00100); mq[0].push_back(t); exp_q[0].push_back(t);
        t = mk(1'b1, 1'b1, 32'h200, 32'hB1B10200); mq[1].push_back(t); exp_q[0].push_back(t);
        @(negedge clk);
        chk("t2_haddr_n", sif[0].HADDR, 32'h100);
        chk("t2_m1_rdy_n", {31'b0, mif[1].HREADY}, 32'd1);
        @(negedge clk);
        chk("t2_haddr_n1", sif[0].HADDR, 32'h200);
        chk("t2_m1_rdy_n1", {31'b0, mif[1].HREADY}, 32'd0);
        chk("t2_m0_rdy_n1", {31'b0, mif[0].HREADY}, 32'd1);
        chk("t2_hwdata_n1", sif[0].HWDATA, 32'hA0A00100);
        @(negedge clk);
        chk("t2_m1_rdy_n2", {31'b0, mif[1].HREADY}, 32'd1);
        chk("t2_hwdata_n2", sif[0].HWDATA, 32'hB1B10200);
        chk("t2_htrans_n2", {30'b0, sif[0].HTRANS}, 32'd0);

        // 3: slave wait states on M0 data phase while M1 is parked
        reset_all();
        @(negedge clk);
        t = mk(1'b0, 1'b1, 32'h300, 32'hC3C30300); mq[0].push_back(t); exp_q[0].push_back(t);
        t = mk(1'b1, 1'b1, 32'h400, 32'hD4D40400); mq[1].push_back(t); exp_q[0].push_back(t);
        @(negedge clk);
        chk("t3_haddr_n", sif[0].HADDR, 32'h300);
        stall[0] = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_stall_haddr", sif[0].HADDR, 32'h400);
            chk("t3_stall_htrans", {30'b0, sif[0].HTRANS}, 32'd2);
            chk("t3_stall_m0_rdy", {31'b0, mif[0].HREADY}, 32'd0);
            chk("t3_stall_m1_rdy", {31'b0, mif[1].HREADY}, 32'd0);
            chk("t3_stall_hwdata", sif[0].HWDATA, 32'hC3C30300);
        end
        @(negedge clk);
        chk("t3_hready4", {31'b0, sif[0].HREADY}, 32'd1);
        chk("t3_haddr4", sif[0].HADDR, 32'h400);
        chk("t3_m0_rdy4", {31'b0, mif[0].HREADY}, 32'd1);
        chk("t3_m1_rdy4", {31'b0, mif[1].HREADY}, 32'd0);
        @(negedge clk);
        chk("t3_hwdata5", sif[0].HWDATA, 32'hD4D40400);
        chk("t3_m1_rdy5", {31'b0, mif[1].HREADY}, 32'd1);

        // 4: continuous traffic on both instances
        reset_all();
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            mq[0].push_back(mk(1'b0, 1'b1, 32'h1000 + 32'(4*i), 32'hC0000000 + 32'(i)));
            mq[1].push_back(mk(1'b1, 1'b1, 32'h2000 + 32'(4*i), 32'hD0000000 + 32'(i)));
            mq[2].push_back(mk(1'b0, 1'b1, 32'h1000 + 32'(4*i), 32'hC0000000 + 32'(i)));
            mq[3].push_back(mk(1'b1, 1'b1, 32'h2000 + 32'(4*i), 32'hD0000000 + 32'(i)));
            exp_q[0].push_back(mk(1'b0, 1'b1, 32'h1000 + 32'(4*i), 32'hC0000000 + 32'(i)));
            exp_q[0].push_back(mk(1'b1, 1'b1, 32'h2000 + 32'(4*i), 32'hD0000000 + 32'(i)));
        end
        for (int i = 0; i < 8; i++)
            exp_q[1].push_back(mk(1'b0, 1'b1, 32'h1000 + 32'(4*i), 32'hC0000000 + 32'(i)));
        for (int i = 0; i < 8; i++)
            exp_q[1].push_back(mk(1'b1, 1'b1, 32'h2000 + 32'(4*i), 32'hD0000000 + 32'(i)));
        for (int i = 0; i < 200 && (exp_q[0].size() > 0 || exp_q[1].size() > 0); i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t4_rr_left", exp_q[0].size(), 32'd0);
        chk("t4_fp_left", exp_q[1].size(), 32'd0);

        // 5: M1 read returns slave data in its data phase
        reset_all();
        @(negedge clk);
        t = mk(1'b1, 1'b0, 32'hBFC00000, 32'hDEADBEEF); mq[1].push_back(t); exp_q[0].push_back(t);
        @(negedge clk);
        chk("t5_haddr", sif[0].HADDR, 32'hBFC00000);
        chk("t5_hwrite", {31'b0, sif[0].HWRITE}, 32'd0);
        @(negedge clk);
        chk("t5_m1_hrdata", mif[1].HRDATA, 32'hDEADBEEF);
        chk("t5_m1_hready", {31'b0, mif[1].HREADY}, 32'd1);

        // 6: reset while M1 is parked; parked address must never appear
        reset_all();
        @(negedge clk);
        t = mk(1'b0, 1'b1, 32'h500, 32'hE0E00500); mq[0].push_back(t); exp_q[0].push_back(t);
        mq[1].push_back(mk(1'b1, 1'b1, 32'h600, 32'hE1E10600));
        @(negedge clk);
        chk("t6_haddr_n", sif[0].HADDR, 32'h500);
        @(posedge clk); #2 rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_htrans", {30'b0, sif[0].HTRANS}, 32'd0);
        chk("t6_rst_hwdata", sif[0].HWDATA, 32'd0);
        chk("t6_rst_m1_rdy", {31'b0, mif[1].HREADY}, 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_post_htrans", {30'b0, sif[0].HTRANS}, 32'd0);
        chk("t6_post_m1_rdy", {31'b0, mif[1].HREADY}, 32'd1);
        chk("t6_post_m0_rdy", {31'b0, mif[0].HREADY}, 32'd1);
        repeat (5) @(negedge clk);
        chk("t6_rr_left", exp_q[0].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end
endmodule
